systolic_array_ctrl_4_4: RTL and testbench
==========================================

Name: systolic_array_ctrl_4_4

Overview:
- Sequencer that drives a 4x4 weight-stationary systolic array from two valid/ready streams: a weight stream and an activation stream.
- Loads weights (mode=1, top-fed, bottom row first), then feeds activation vectors with a per-row skew of k cycles.
- Deskews the bottom-edge column outputs into aligned result vectors on a valid-only output stream.
- Sits between the NICE command/memory front end and systolic_array_4_4, replacing hand-written stimulus sequencing.

Parameters:
- DATA_WIDTH, 32, signed element width.
- OUT_LAT, 4, cycles from an element on left row 0 to its result on down column 0 (array property).

Ports:
- ctrl_clk  in  1  clock.
- ctrl_rst_n  in  1  asynchronous, active-low reset.
- w_valid  in  1  weight beat valid.
- w_ready  out  1  weight beat accepted when w_valid&w_ready.
- w_data  in  4*DATA_WIDTH  one weight row; lane j=[j*DW+:DW]; beat 0 = bottom array row (row 3).
- x_valid  in  1  activation vector valid.
- x_ready  out  1  activation accept.
- x_data  in  4*DATA_WIDTH  activation vector; lane k goes to array row k.
- x_last  in  1  marks final vector of a batch.
- y_valid  out  1  aligned result vector valid; no backpressure, the sink must take every beat.
- y_data  out  4*DATA_WIDTH  lane j = array column j result.
- y_last  out  1  result for the x_last vector.
- busy  out  1  high when the FSM is not in IDLE.
- weights_loaded  out  1  a full 4-beat weight set is resident.
- arr_mode  out  16  mode for every PE, [i*4+j].
- arr_en_up  out  4  top-edge enables.
- arr_data_up  out  4*DATA_WIDTH  top-edge data.
- arr_en_left  out  4  left-edge enables.
- arr_data_left  out  4*DATA_WIDTH  left-edge data.
- arr_data_down  in  4*DATA_WIDTH  bottom-edge outputs of row 3.

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; weights_loaded=0; all delay lines, the valid/last tracking pipe, and the beat counter cleared. Reset mid-batch abandons the batch with no partial y output.
- IDLE:
  - w_valid=1 -> LOAD. w_valid has priority over x_valid.
  - Otherwise x_valid=1 and weights_loaded=1 -> FEED.
  - x_valid with weights_loaded=0 is ignored; x_ready stays 0.
- LOAD:
  - arr_mode=all 1; w_ready=1.
  - arr_en_up=4'hF and arr_data_up=w_data only in cycles where a beat is accepted. In gap cycles arr_en_up=0 and arr_data_up=0.
  - A 2-bit counter counts accepted beats; after beat 3 -> FEED if x_valid, else IDLE. weights_loaded=1 from that edge.
  - Entry to LOAD clears weights_loaded.
- Outside LOAD: arr_mode=0, arr_en_up=0, arr_data_up=0. A zero data_up is mandatory.
- FEED:
  - x_ready=1; arr_en_left=4'hF.
  - Each cycle, input vector v = x_data if accepted, else zero (bubble).
  - arr_data_left lane k = lane k of v delayed k registered cycles. Lane 0 is combinational from v, so a vector accepted in cycle n drives row k in cycle n+k.
  - On accepted x_last -> DRAIN.
- DRAIN:
  - x_ready=0; arr_en_left=4'hF; zero vectors injected.
  - Stays until the tracking pipe is empty: 7 cycles after the last accept. Then -> IDLE and arr_en_left=0.
- Output alignment:
  - Result j of vector n appears on arr_data_down lane j in cycle n+j+OUT_LAT.
  - Lane j is registered through 3-j delay stages, so the aligned vector emerges in cycle n+3+OUT_LAT (latency 7 with defaults, accept to y_valid).
- Valid/last tracking: a shift pipe of depth 3+OUT_LAT carries the accepted and x_last flags. y_valid and y_last are its tail; bubbles produce no y_valid.
- Back-to-back batches: x_valid in IDLE may start a new FEED immediately after DRAIN ends. There is no overlap of batches.
- Arithmetic: the block performs no arithmetic; data passes bit-exact and signed.

Decomposition:
- Package sa_pkg holds:
  - DATA_WIDTH default, ARRAY_N=4, OUT_LAT.
  - Derived ALIGN_LAT = ARRAY_N-1+OUT_LAT.
  - State enum {IDLE, LOAD, FEED, DRAIN}.
- One sub-module, sa_delay_line: parameter DEPTH (0 = wire) and WIDTH, async active-low clear. It is instantiated for the 3 input-skew lanes and 3 output-deskew lanes.

Test Plan:
- Load weight beats (4,8,12,16), (3,7,11,15), (2,6,10,14), (1,5,9,13) -> arr_mode=all 1 and arr_en_up=F on 4 consecutive cycles; arr_data_up = beats in that order; weights_loaded=1 after beat 4.
- Stream x=(1,4,7,10), (2,5,8,11), (3,6,9,12 with x_last) -> y=(70,158,246,334), (80,184,288,392), (90,210,330,450); first y_valid 7 cycles after first accept; y_last on the third vector.
- Same stream with x_valid low for 2 cycles between vectors 1 and 2 -> identical y values, with a 2-cycle y_valid gap and no spurious beats.
- Insert a 1-cycle w_valid gap during LOAD -> arr_en_up=0 and arr_data_up=0 in the gap; same results as the second test afterwards.
- x_valid with weights_loaded=0 -> x_ready stays 0 and busy=0. Then reuse already-loaded weights for a second batch -> FEED entered with no LOAD.
- Assert ctrl_rst_n mid-FEED -> all outputs 0 immediately; weights_loaded=0; no y_valid after release.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared constants, FSM state encoding and tracking-pipe entry for the
// 4x4 systolic array sequencer.
package sa_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int ARRAY_N        = 4;
  localparam int DEF_OUT_LAT    = 4;
  // Cycles from vector accept to its aligned result vector.
  localparam int ALIGN_LAT      = ARRAY_N - 1 + DEF_OUT_LAT;

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_e;

  // One stage of the valid/last tracking pipe.
  typedef struct packed {
    logic vld;
    logic last;
  } trk_t;
endpackage

// File: rtl/sa_delay_line.sv
// Fixed-depth register delay line with async active-low clear.
// DEPTH=0 degenerates to a wire.
module sa_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_regs
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    // Shift one stage per cycle, new sample enters stage 0.
    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    // Stage registers, cleared on reset so no stale data leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= '0;
      else        stage_q <= stage_d;
    end

    assign q = stage_q[DEPTH-1];
  end
endmodule

// File: rtl/systolic_array_ctrl_4_4.sv
// Sequencer for a 4x4 weight-stationary systolic array: loads weights
// top-down, feeds skewed activation vectors on the left edge and deskews
// the bottom-edge outputs into aligned result vectors.
module systolic_array_ctrl_4_4
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OUT_LAT    = DEF_OUT_LAT
) (
  input  logic                            ctrl_clk,
  input  logic                            ctrl_rst_n,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]   w_data,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]   x_data,
  input  logic                            x_last,
  output logic                            y_valid,
  output logic [ARRAY_N*DATA_WIDTH-1:0]   y_data,
  output logic                            y_last,
  output logic                            busy,
  output logic                            weights_loaded,
  output logic [ARRAY_N*ARRAY_N-1:0]      arr_mode,
  output logic [ARRAY_N-1:0]              arr_en_up,
  output logic [ARRAY_N*DATA_WIDTH-1:0]   arr_data_up,
  output logic [ARRAY_N-1:0]              arr_en_left,
  output logic [ARRAY_N*DATA_WIDTH-1:0]   arr_data_left,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]   arr_data_down
);
  // Package latency tracks the default OUT_LAT; adjust if overridden.
  localparam int AL = ALIGN_LAT + (OUT_LAT - DEF_OUT_LAT);

  typedef logic [ARRAY_N-1:0][DATA_WIDTH-1:0] vec_t;

  state_e     state_q, state_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;
  logic       weights_loaded_q, weights_loaded_d;
  trk_t [AL:1] vld_pipe_q, vld_pipe_d;

  logic w_acc, x_acc, load, pipe_busy;
  vec_t x_vec, v, skew, down, aligned;

  assign w_acc = w_valid & w_ready;
  assign x_acc = x_valid & x_ready;

  // Anything still in flight except the tail means results are pending.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 1; i < AL; i++) pipe_busy = pipe_busy | vld_pipe_q[i].vld;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    weights_loaded_d = weights_loaded_q;
    w_ready          = 1'b0;
    x_ready          = 1'b0;
    arr_en_left      = '0;
    load             = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_valid) begin
          state_d          = LOAD;
          weights_loaded_d = 1'b0;
          beat_cnt_d       = '0;
        end else if (x_valid && weights_loaded_q) begin
          state_d = FEED;
        end
      end
      LOAD: begin
        load    = 1'b1;
        w_ready = 1'b1;
        if (w_valid) begin
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            weights_loaded_d = 1'b1;
            state_d          = x_valid ? FEED : IDLE;
          end
        end
      end
      FEED: begin
        x_ready     = 1'b1;
        arr_en_left = '1;
        if (x_valid && x_last) state_d = DRAIN;
      end
      DRAIN: begin
        arr_en_left = '1;
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid/last tracking pipe; bubbles enter as invalid entries.
  always_comb begin
    vld_pipe_d         = vld_pipe_q;
    vld_pipe_d[1].vld  = x_acc;
    vld_pipe_d[1].last = x_acc & x_last;
    for (int i = 2; i <= AL; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
  end

  // Control state registers.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_q          <= IDLE;
      beat_cnt_q       <= '0;
      weights_loaded_q <= 1'b0;
      vld_pipe_q       <= '0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      weights_loaded_q <= weights_loaded_d;
      vld_pipe_q       <= vld_pipe_d;
    end
  end

  // Weight path: top edge only carries data on accepted beats, zero otherwise.
  assign arr_mode    = {(ARRAY_N*ARRAY_N){load}};
  assign arr_en_up   = {ARRAY_N{w_acc}};
  assign arr_data_up = w_acc ? w_data : '0;

  // Activation path: unaccepted cycles inject a zero bubble.
  assign x_vec = x_data;
  assign v     = x_acc ? x_vec : '0;
  assign down  = arr_data_down;

  // Row k is skewed by k cycles; column j is deskewed by N-1-j cycles.
  for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
    if (g == 0) begin : g_skew_wire
      assign skew[g] = v[g];
    end else begin : g_skew_regs
      sa_delay_line #(.DEPTH(g), .WIDTH(DATA_WIDTH)) u_skew (
        .clk(ctrl_clk), .rst_n(ctrl_rst_n), .d(v[g]), .q(skew[g])
      );
    end
    if (g == ARRAY_N - 1) begin : g_deskew_wire
      assign aligned[g] = down[g];
    end else begin : g_deskew_regs
      sa_delay_line #(.DEPTH(ARRAY_N - 1 - g), .WIDTH(DATA_WIDTH)) u_deskew (
        .clk(ctrl_clk), .rst_n(ctrl_rst_n), .d(down[g]), .q(aligned[g])
      );
    end
  end

  assign arr_data_left  = (arr_en_left != '0) ? skew : '0;
  assign y_valid        = vld_pipe_q[AL].vld;
  assign y_last         = vld_pipe_q[AL].last;
  // Gate data with valid so the stream is quiet between results and in reset.
  assign y_data         = y_valid ? aligned : '0;
  assign busy           = (state_q != IDLE);
  assign weights_loaded = weights_loaded_q;
endmodule

// File: tb/tb_systolic_array_ctrl_4_4.sv
// Directed bench for systolic_array_ctrl_4_4 with a behavioural 4x4
// weight-stationary array model closing the loop on arr_data_down.
module tb_systolic_array_ctrl_4_4;
  localparam int DW = 32;

  logic           ctrl_clk = 1'b0;
  logic           ctrl_rst_n;
  logic           w_valid, w_ready, x_valid, x_ready, x_last;
  logic [4*DW-1:0] w_data, x_data, y_data, arr_data_up, arr_data_left;
  logic [4*DW-1:0] arr_data_down = '0;
  logic           y_valid, y_last, busy, weights_loaded;
  logic [15:0]    arr_mode;
  logic [3:0]     arr_en_up, arr_en_left;

  systolic_array_ctrl_4_4 dut (
    .ctrl_clk(ctrl_clk), .ctrl_rst_n(ctrl_rst_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last),
    .busy(busy), .weights_loaded(weights_loaded),
    .arr_mode(arr_mode), .arr_en_up(arr_en_up), .arr_data_up(arr_data_up),
    .arr_en_left(arr_en_left), .arr_data_left(arr_data_left),
    .arr_data_down(arr_data_down)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hist[4096][4];

  typedef struct {
    logic [4*DW-1:0] d;
    logic            l;
    int              c;
  } ybeat_t;
  ybeat_t yq[$];

  logic [4*DW-1:0] beats[4];
  logic [4*DW-1:0] xv[3];
  logic [4*DW-1:0] yv[3];

  // Array weights W[row][col] as loaded by the test-plan beats.
  function automatic int wgt(int k, int j);
    return 1 + k + 4 * j;
  endfunction

  // Array model: column j in cycle t sums row k inputs from cycle t-j-4+k.
  always @(posedge ctrl_clk) begin
    int s, idx;
    logic [4*DW-1:0] dn;
    cyc = cyc + 1;
    #1;
    dn = '0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        idx = cyc - j - 4 + k;
        if (idx >= 0 && idx < 4096) s = s + wgt(k, j) * hist[idx][k];
      end
      dn[j*DW +: DW] = s;
    end
    arr_data_down = dn;
  end

  // Record left-edge inputs and collect result beats.
  always @(negedge ctrl_clk) begin
    if (cyc < 4096)
      for (int k = 0; k < 4; k++)
        hist[cyc][k] = arr_en_left[k] ? int'($signed(arr_data_left[k*DW +: DW])) : 0;
    if (y_valid) yq.push_back('{y_data, y_last, cyc});
  end

  task automatic tick;
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic test_reset;
    ctrl_rst_n = 1'b0;
    w_valid = 0; w_data = '0; x_valid = 0; x_data = '0; x_last = 0;
    #2;
    total++;
    if (busy !== 0 || w_ready !== 0 || x_ready !== 0 || y_valid !== 0 || y_last !== 0 || weights_loaded !== 0) begin
      bad++; $display("FAIL reset_ctl: busy=%b w_ready=%b x_ready=%b y_valid=%b y_last=%b wl=%b want all 0",
                      busy, w_ready, x_ready, y_valid, y_last, weights_loaded);
    end
    total++;
    if (arr_mode !== 0 || arr_en_up !== 0 || arr_en_left !== 0 || arr_data_up !== 0 || arr_data_left !== 0 || y_data !== 0) begin
      bad++; $display("FAIL reset_data: mode=%h en_up=%h en_left=%h up=%h left=%h y=%h want 0",
                      arr_mode, arr_en_up, arr_en_left, arr_data_up, arr_data_left, y_data);
    end
    repeat (3) tick;
    ctrl_rst_n = 1'b1;
  endtask

  task automatic test_no_weights;
    tick; x_valid = 1; x_data = xv[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge ctrl_clk);
      total++;
      if (x_ready !== 0 || busy !== 0) begin
        bad++; $display("FAIL no_weights cyc %0d: x_ready=%b busy=%b want 0/0", i, x_ready, busy);
      end
    end
    tick; x_valid = 0; x_data = '0;
  endtask

  task automatic test_load(input bit gap);
    tick; w_valid = 1; w_data = beats[0];
    tick;
    for (int b = 0; b < 4; b++) begin
      @(negedge ctrl_clk);
      total++;
      if (arr_en_up !== 4'hF || arr_mode !== 16'hFFFF || w_ready !== 1'b1 || busy !== 1'b1) begin
        bad++; $display("FAIL load_ctl beat %0d: en_up=%h mode=%h w_ready=%b busy=%b want F/FFFF/1/1",
                        b, arr_en_up, arr_mode, w_ready, busy);
      end
      total++;
      if (arr_data_up !== beats[b]) begin
        bad++; $display("FAIL load_data beat %0d: got %h want %h", b, arr_data_up, beats[b]);
      end
      if (b == 0) begin
        total++;
        if (weights_loaded !== 1'b0) begin
          bad++; $display("FAIL load_entry_wl: got %b want 0", weights_loaded);
        end
      end
      tick;
      if (gap && b == 1) begin
        w_valid = 0; w_data = {4{32'hDEADBEEF}};
        @(negedge ctrl_clk);
        total++;
        if (arr_en_up !== 0 || arr_data_up !== 0 || arr_mode !== 16'hFFFF || w_ready !== 1'b1) begin
          bad++; $display("FAIL load_gap: en_up=%h up=%h mode=%h w_ready=%b want 0/0/FFFF/1",
                          arr_en_up, arr_data_up, arr_mode, w_ready);
        end
        tick;
      end
      if (b < 3) begin w_valid = 1; w_data = beats[b+1]; end
      else begin w_valid = 0; w_data = '0; end
    end
    @(negedge ctrl_clk);
    total++;
    if (weights_loaded !== 1'b1 || busy !== 1'b0 || arr_mode !== 0 || arr_en_up !== 0) begin
      bad++; $display("FAIL load_done: wl=%b busy=%b mode=%h en_up=%h want 1/0/0/0",
                      weights_loaded, busy, arr_mode, arr_en_up);
    end
  endtask

  task automatic test_stream(input int gap);
    int acc[3];
    int n;
    yq.delete();
    tick; x_valid = 1; x_data = xv[0]; x_last = 0;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge ctrl_clk);
      total++;
      if (x_ready !== 1'b1 || busy !== 1'b1 || arr_mode !== 0 || arr_en_left !== 4'hF || weights_loaded !== 1'b1) begin
        bad++; $display("FAIL feed_ctl vec %0d: x_ready=%b busy=%b mode=%h en_left=%h wl=%b want 1/1/0/F/1",
                        i, x_ready, busy, arr_mode, arr_en_left, weights_loaded);
      end
      acc[i] = cyc;
      tick;
      if (i == 0 && gap > 0) begin
        x_valid = 0; x_data = '0;
        repeat (gap) tick;
      end
      if (i < 2) begin x_valid = 1; x_data = xv[i+1]; x_last = (i + 1 == 2); end
      else begin x_valid = 0; x_data = '0; x_last = 0; end
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge ctrl_clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL drain_timeout: busy=%b want 0 within 40 cycles", busy);
    end
    total++;
    if (yq.size() !== 3) begin
      bad++; $display("FAIL y_count gap=%0d: got %0d want 3", gap, yq.size());
    end
    for (int i = 0; i < 3 && i < yq.size(); i++) begin
      total++;
      if (yq[i].d !== yv[i]) begin
        bad++; $display("FAIL y_data vec %0d: got %h want %h", i, yq[i].d, yv[i]);
      end
      total++;
      if (yq[i].l !== (i == 2)) begin
        bad++; $display("FAIL y_last vec %0d: got %b want %b", i, yq[i].l, (i == 2));
      end
      total++;
      if (yq[i].c !== acc[i] + 7) begin
        bad++; $display("FAIL y_latency vec %0d: got cycle %0d want %0d", i, yq[i].c, acc[i] + 7);
      end
    end
  endtask

  task automatic test_reset_mid_feed;
    tick; x_valid = 1; x_data = xv[0]; x_last = 0;
    repeat (3) tick;
    ctrl_rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 0 || x_ready !== 0 || arr_en_left !== 0 || arr_data_left !== 0 || weights_loaded !== 0 || y_valid !== 0 || y_data !== 0) begin
      bad++; $display("FAIL mid_reset_out: busy=%b x_ready=%b en_left=%h left=%h wl=%b y_valid=%b y=%h want 0",
                      busy, x_ready, arr_en_left, arr_data_left, weights_loaded, y_valid, y_data);
    end
    x_valid = 0; x_data = '0;
    yq.delete();
    repeat (2) tick;
    ctrl_rst_n = 1'b1;
    repeat (15) tick;
    total++;
    if (yq.size() !== 0) begin
      bad++; $display("FAIL mid_reset_y: got %0d beats want 0", yq.size());
    end
    total++;
    if (weights_loaded !== 0 || busy !== 0) begin
      bad++; $display("FAIL mid_reset_state: wl=%b busy=%b want 0/0", weights_loaded, busy);
    end
  endtask

  initial begin
    beats[0] = {32'd16, 32'd12, 32'd8,  32'd4};
    beats[1] = {32'd15, 32'd11, 32'd7,  32'd3};
    beats[2] = {32'd14, 32'd10, 32'd6,  32'd2};
    beats[3] = {32'd13, 32'd9,  32'd5,  32'd1};
    xv[0] = {32'd10, 32'd7, 32'd4, 32'd1};
    xv[1] = {32'd11, 32'd8, 32'd5, 32'd2};
    xv[2] = {32'd12, 32'd9, 32'd6, 32'd3};
    yv[0] = {32'd334, 32'd246, 32'd158, 32'd70};
    yv[1] = {32'd392, 32'd288, 32'd184, 32'd80};
    yv[2] = {32'd450, 32'd330, 32'd210, 32'd90};

    test_reset();
    test_no_weights();
    test_load(1'b0);
    test_stream(0);
    test_stream(2);
    test_load(1'b1);
    test_stream(0);
    test_reset_mid_feed();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
